// File: rtl/acc_pkg.sv
// Shared constants for the accelerator input path: byte lane width, word packing factor,
// statistics counter width, and a helper sizing the packer's fill counter.
package acc_pkg;

    localparam int ACC_BYTE_W         = 8;
    localparam int ACC_BYTES_PER_WORD = 4;
    localparam int ACC_COUNT_W        = 16;

    // Fill counts 0..N inclusive, so one bit more than the byte index needs.
    function automatic int acc_fill_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from a standard-mode sync FIFO (1-cycle read latency) and packs them LSB-first into words.
// Optional build macro FIFO_PACKER_STATS_EN adds the word_count port counting accepted words.
module fifo_word_packer
    import acc_pkg::*;
#(
    parameter int DATA_W         = ACC_BYTE_W,
    parameter int BYTES_PER_WORD = ACC_BYTES_PER_WORD
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fifo_empty,
    input  logic [DATA_W-1:0]                  fifo_dout,
    output logic                               fifo_rd_en,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   out_data
`ifdef FIFO_PACKER_STATS_EN
    ,
    output logic [ACC_COUNT_W-1:0]             word_count
`endif
);

    localparam int N      = BYTES_PER_WORD;
    localparam int WORD_W = DATA_W * N;
    localparam int ASM_W  = DATA_W * (N - 1);
    localparam int CNT_W  = acc_fill_w(N);

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;

    logic [CNT_W-1:0]  fill;
    logic              out_fire;
    logic              completing;

    // Handshake: a word transfers on any rising edge where out_valid && out_ready; while out_valid is
    // high and out_ready low, out_data is held unchanged. out_valid never drops without a transfer.
    always_comb begin
        fill       = byte_cnt_q + CNT_W'(rd_pending_q);
        out_fire   = out_valid_q && out_ready;
        completing = rd_pending_q && (byte_cnt_q == CNT_W'(N - 1));

        // The completing byte may only be in flight if the output register is free when it lands.
        fifo_rd_en = rst_n && !fifo_empty &&
                     !((fill == CNT_W'(N - 1)) && out_valid_q && !out_ready);

        rd_pending_d = fifo_rd_en;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (rd_pending_q) begin
            if (completing) begin
                out_data_d  = {fifo_dout, asm_q};
                out_valid_d = 1'b1;
                byte_cnt_d  = '0;
            end else begin
                for (int i = 0; i < N - 1; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) begin
                        asm_d[i*DATA_W +: DATA_W] = fifo_dout;
                    end
                end
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            asm_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            rd_pending_q <= rd_pending_d;
            asm_q        <= asm_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FIFO_PACKER_STATS_EN
    logic [ACC_COUNT_W-1:0] word_count_q, word_count_d;

    // Wraps naturally from all-ones to zero.
    always_comb begin
        word_count_d = word_count_q + (out_fire ? ACC_COUNT_W'(1) : ACC_COUNT_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule
